// File: rtl/csr_trap_seq.sv
// Trap/mret sequencer that owns the single CSR write port and issues the fetch redirect.
// Define CSR_TRAP_VECTORED_EN to honour mtvec vectored mode for interrupt causes.
module csr_trap_seq #(
  parameter int XLEN          = 64,
  parameter int CAUSE_INT_BIT = 63
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_req_valid,
  input  logic [11:0]     csr_req_addr,
  input  logic [XLEN-1:0] csr_req_wdata,
  output logic            csr_req_ready,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  output logic            trap_ready,
  input  logic            mret_valid,
  output logic            mret_ready,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            csr_we,
  output logic [11:0]     csr_addr_write,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, M_MSTATUS, REDIR
  } state_t;

  state_t          state;
  logic [XLEN-1:0] cause_q, pc_q, tval_q;
  logic            is_trap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      is_trap_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_valid) begin
            cause_q   <= trap_cause;
            pc_q      <= trap_pc;
            tval_q    <= trap_tval;
            is_trap_q <= 1'b1;
            state     <= T_MEPC;
          end else if (mret_valid) begin
            is_trap_q <= 1'b0;
            state     <= M_MSTATUS;
          end
        end
        T_MEPC:    state <= T_MCAUSE;
        T_MCAUSE:  state <= T_MTVAL;
        T_MTVAL:   state <= T_MSTATUS;
        T_MSTATUS: state <= REDIR;
        M_MSTATUS: state <= REDIR;
        REDIR:     state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] trap_mstatus, mret_mstatus, trap_base, trap_target;

  always_comb begin
    trap_mstatus        = mstatus_in;
    trap_mstatus[7]     = mstatus_in[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = mstatus_in;
    mret_mstatus[3]     = mstatus_in[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b00;
  end

  assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  // Interrupt causes land at base + 4*code; the shift drops any carry out of XLEN.
  always_comb begin
    trap_target = trap_base;
    if (mtvec_in[1:0] == 2'b01 && cause_q[CAUSE_INT_BIT])
      trap_target = trap_base + ({1'b0, cause_q[XLEN-2:0]} << 2);
  end
`else
  logic unused_mode;
  assign unused_mode = ^{mtvec_in[1:0], cause_q[CAUSE_INT_BIT]};
  assign trap_target = trap_base;
`endif

  always_comb begin
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    csr_req_ready  = 1'b0;
    csr_we         = 1'b0;
    csr_addr_write = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (trap_valid)         trap_ready = 1'b1;
        else if (mret_valid)    mret_ready = 1'b1;
        else if (csr_req_valid) begin
          csr_req_ready  = 1'b1;
          csr_we         = 1'b1;
          csr_addr_write = csr_req_addr;
          csr_wdata      = csr_req_wdata;
        end
      end
      T_MEPC:    begin csr_we = 1'b1; csr_addr_write = A_MEPC;    csr_wdata = pc_q;         end
      T_MCAUSE:  begin csr_we = 1'b1; csr_addr_write = A_MCAUSE;  csr_wdata = cause_q;      end
      T_MTVAL:   begin csr_we = 1'b1; csr_addr_write = A_MTVAL;   csr_wdata = tval_q;       end
      T_MSTATUS: begin csr_we = 1'b1; csr_addr_write = A_MSTATUS; csr_wdata = trap_mstatus; end
      M_MSTATUS: begin csr_we = 1'b1; csr_addr_write = A_MSTATUS; csr_wdata = mret_mstatus; end
      REDIR: begin
        redirect_valid = 1'b1;
        // mepc_in is read here, after the sequence, so it sees any earlier mepc write.
        redirect_pc    = is_trap_q ? trap_target : mepc_in;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
